// File: rtl/alu_exec_pkg.sv
// -----------------------------------------------------------------------------
// alu_exec_pkg
// Shared definitions for the ALU execution stage:
//   - register file geometry (NUM_REGS, DATA_W)
//   - opcode encodings
//   - FSM state encoding and opcode class
//   - helpers that classify an opcode and check its register indices
// Optional feature macro: ALU_EXEC_MUL_EN (makes opcode 12 MUL a legal
// binary operation).
// -----------------------------------------------------------------------------
package alu_exec_pkg;

  localparam int unsigned NUM_REGS = 6;
  localparam int unsigned DATA_W   = 8;

`ifdef ALU_EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MOV = 4'd8;
  localparam logic [3:0] OP_INC = 4'd9;
  localparam logic [3:0] OP_DEC = 4'd10;
  localparam logic [3:0] OP_CMP = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_EXEC,
    S_WB
  } state_t;

  // BINARY: reads A and B, writes back.  UNARY: reads A, writes back.
  // NOWB: reads A and B, updates flags only (CMP).
  typedef enum logic [1:0] {
    CLS_BINARY,
    CLS_UNARY,
    CLS_NOWB,
    CLS_ILLEGAL
  } op_class_t;

  function automatic op_class_t classify(input logic [3:0] op);
    op_class_t cls;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:                cls = CLS_BINARY;
      OP_NOT, OP_SHL, OP_SHR, OP_MOV, OP_INC, OP_DEC:      cls = CLS_UNARY;
      OP_CMP:                                               cls = CLS_NOWB;
      OP_MUL:                                               cls = MUL_EN ? CLS_BINARY : CLS_ILLEGAL;
      default:                                              cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

  function automatic logic reg_ok(input logic [2:0] idx);
    return (32'(idx) < NUM_REGS);
  endfunction

  // Only the indices an instruction actually uses are range-checked.
  function automatic logic operands_ok(input op_class_t cls, input logic [2:0] a,
                                       input logic [2:0] b, input logic [2:0] d);
    logic ok;
    case (cls)
      CLS_BINARY: ok = reg_ok(a) && reg_ok(b) && reg_ok(d);
      CLS_UNARY:  ok = reg_ok(a) && reg_ok(d);
      CLS_NOWB:   ok = reg_ok(a) && reg_ok(b);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_exec_unit_alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational datapath of the ALU execution stage.
// Ports:
//   op     in  4       operation code
//   a, b   in  DATA_W  operands (b ignored by unary operations)
//   result out DATA_W  8-bit result, wraps modulo 256
//   carry  out 1       carry / borrow / shifted-out bit, 0 for logic ops
// Optional feature macro: ALU_EXEC_MUL_EN (adds the 8x8 multiplier path).
// -----------------------------------------------------------------------------
module alu_core
  import alu_exec_pkg::*;
(
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  // Bit DATA_W of the widened result is the carry/borrow for every operation.
  logic [DATA_W:0] wide;

`ifdef ALU_EXEC_MUL_EN
  logic [2*DATA_W-1:0] prod;
  assign prod = a * b;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and infers a latch.
    wide = '0;
    case (op)
      OP_ADD:         wide = {1'b0, a} + {1'b0, b};
      OP_SUB, OP_CMP: wide = {1'b0, a} - {1'b0, b};   // bit 8 = borrow
      OP_AND:         wide = {1'b0, a & b};
      OP_OR:          wide = {1'b0, a | b};
      OP_XOR:         wide = {1'b0, a ^ b};
      OP_NOT:         wide = {1'b0, ~a};
      OP_SHL:         wide = {a, 1'b0};
      OP_SHR:         wide = {a[0], 1'b0, a[DATA_W-1:1]};
      OP_MOV:         wide = {1'b0, a};
      OP_INC:         wide = {1'b0, a} + 9'd1;
      OP_DEC:         wide = {1'b0, a} - 9'd1;
`ifdef ALU_EXEC_MUL_EN
      OP_MUL:         wide = {|prod[2*DATA_W-1:DATA_W], prod[DATA_W-1:0]};
`endif
      default:        wide = '0;
    endcase
    result = wide[DATA_W-1:0];
    carry  = wide[DATA_W];
  end

endmodule

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
// ALU execution stage in front of the 6 x 8-bit register file. Accepts one
// decoded instruction, reads its source registers, computes, writes back and
// pulses done. Maintains zero and carry flags.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, opcode, src_a,
//   src_b, dst               instruction request (sampled only in IDLE)
//   busy                     instruction in flight
//   done, err                one-cycle completion pulse / rejection flag
//   flag_z, flag_c           zero / carry-borrow flags
//   rf_addr, rf_rd, rf_wr,
//   rf_wdata, rf_rdata       register file bus (rdata valid same cycle as rd)
// Optional feature macro: ALU_EXEC_MUL_EN (opcode 12 MUL legal).
// -----------------------------------------------------------------------------
module alu_exec_unit
  import alu_exec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        opcode,
  input  logic [2:0]        src_a,
  input  logic [2:0]        src_b,
  input  logic [2:0]        dst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              flag_z,
  output logic              flag_c,
  output logic [2:0]        rf_addr,
  output logic              rf_rd,
  output logic              rf_wr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata
);

  state_t            state;
  logic [3:0]        opc;
  logic [2:0]        sa, sb, dd;
  logic [DATA_W-1:0] op_a, op_b, result;

  op_class_t         new_cls, cls;
  logic [DATA_W-1:0] core_result;
  logic              core_carry;

  assign new_cls = classify(opcode);
  assign cls     = classify(opc);

  alu_core u_core (
    .op     (opc),
    .a      (op_a),
    .b      (op_b),
    .result (core_result),
    .carry  (core_carry)
  );

  // Bus outputs are registered and loaded on the edge that enters the state
  // that owns them, so they are valid for the whole RD_A/RD_B/WB cycle and
  // drop asynchronously with rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      opc      <= '0;
      sa       <= '0;
      sb       <= '0;
      dd       <= '0;
      op_a     <= '0;
      op_b     <= '0;
      result   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
      rf_addr  <= '0;
      rf_rd    <= 1'b0;
      rf_wr    <= 1'b0;
      rf_wdata <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      done     <= 1'b0;
      err      <= 1'b0;
      rf_rd    <= 1'b0;
      rf_wr    <= 1'b0;
      rf_addr  <= '0;
      rf_wdata <= '0;

      case (state)
        S_IDLE: begin
          if (start) begin
            opc <= opcode;
            sa  <= src_a;
            sb  <= src_b;
            dd  <= dst;
            if (operands_ok(new_cls, src_a, src_b, dst)) begin
              state   <= S_RD_A;
              busy    <= 1'b1;
              rf_rd   <= 1'b1;
              rf_addr <= src_a;
            end else begin
              // Rejected: no bus activity, flags untouched.
              done <= 1'b1;
              err  <= 1'b1;
            end
          end
        end

        S_RD_A: begin
          op_a <= rf_rdata;
          if (cls == CLS_UNARY) begin
            state <= S_EXEC;
          end else begin
            state   <= S_RD_B;
            rf_rd   <= 1'b1;
            rf_addr <= sb;
          end
        end

        S_RD_B: begin
          op_b  <= rf_rdata;
          state <= S_EXEC;
        end

        S_EXEC: begin
          result <= core_result;
          flag_z <= (core_result == '0);
          flag_c <= core_carry;
          if (cls == CLS_NOWB) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state    <= S_WB;
            rf_wr    <= 1'b1;
            rf_addr  <= dd;
            rf_wdata <= core_result;
          end
        end

        S_WB: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_unit
// Self-checking bench for alu_exec_unit. Holds a behavioural register file on
// the DUT bus, a reference model computing result/flags/legality from the
// instruction rules, and a per-cycle expected-output queue built from the
// latency rules. One compare process checks every cycle at the falling edge.
// Follows ALU_EXEC_MUL_EN the same way the RTL does.
// -----------------------------------------------------------------------------
module tb_alu_exec_unit;

`ifdef ALU_EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] opcode;
  logic [2:0] src_a, src_b, dst;
  logic       busy, done, err, flag_z, flag_c;
  logic [2:0] rf_addr;
  logic       rf_rd, rf_wr;
  logic [7:0] rf_wdata, rf_rdata;

  always #5 clk = ~clk;

  alu_exec_unit dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .src_a(src_a), .src_b(src_b), .dst(dst),
    .busy(busy), .done(done), .err(err), .flag_z(flag_z), .flag_c(flag_c),
    .rf_addr(rf_addr), .rf_rd(rf_rd), .rf_wr(rf_wr),
    .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
  );

  // ---------------- register file on the bus ----------------
  logic [7:0] rf_mem [6];
  logic       pre_we = 1'b0;
  logic [2:0] pre_addr = '0;
  logic [7:0] pre_data = '0;

  assign rf_rdata = (rf_addr < 3'd6) ? rf_mem[rf_addr] : 8'h00;

  always @(posedge clk) begin
    if (rf_wr && rf_addr < 3'd6) rf_mem[rf_addr] <= rf_wdata;
    else if (pre_we)             rf_mem[pre_addr] <= pre_data;
  end

  // ---------------- reference model ----------------
  int unsigned model_rf [6];

  typedef struct packed {
    logic       legal;
    logic       two_src;
    logic       wb;
    logic [7:0] res;
    logic       z;
    logic       c;
  } model_t;

  function automatic model_t model(input int op, input int a, input int b, input int d);
    model_t m;
    int va, vb, r;
    bit cy, binop, unop;
    binop = (op <= 4) || op == 11 || (op == 12 && MUL_EN);
    unop  = (op >= 5 && op <= 10);
    m = '0;
    m.two_src = binop;
    m.wb      = (op != 11);
    m.legal   = (binop && a < 6 && b < 6 && (op == 11 || d < 6)) ||
                (unop && a < 6 && d < 6);
    va = (a < 6) ? int'(model_rf[a]) : 0;
    vb = (b < 6) ? int'(model_rf[b]) : 0;
    r = 0; cy = 0;
    case (op)
      0:      begin r = va + vb;  cy = (r > 255); end
      1, 11:  begin r = va - vb;  cy = (va < vb); end
      2:      r = va & vb;
      3:      r = va | vb;
      4:      r = va ^ vb;
      5:      r = 255 - va;
      6:      begin r = va * 2;   cy = (va >= 128); end
      7:      begin r = va / 2;   cy = (va % 2 == 1); end
      8:      r = va;
      9:      begin r = va + 1;   cy = (va == 255); end
      10:     begin r = va - 1;   cy = (va == 0); end
      12:     begin r = va * vb;  cy = (r > 255); end
      default: r = 0;
    endcase
    r = r & 255;
    m.res = 8'(r);
    m.z   = (r == 0);
    m.c   = cy;
    return m;
  endfunction

  // ---------------- expected per-cycle outputs ----------------
  typedef struct packed {
    logic       busy, done, err, rd, wr;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic       z, c;
  } vec_t;

  vec_t exp_q[$];
  logic cur_z = 1'b0, cur_c = 1'b0;
  bit   chk_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic bsy, dn, er, rd, wr, input logic [2:0] ad,
                              input logic [7:0] wd, input logic z, c);
    vec_t v;
    v = {bsy, dn, er, rd, wr, ad, wd, z, c};
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      vec_t e, a;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cur_z = e.z;
        cur_c = e.c;
      end else begin
        e = mk(0, 0, 0, 0, 0, 3'd0, 8'h00, cur_z, cur_c);
      end
      // Write data is only meaningful while the write strobe is expected.
      a = mk(busy, done, err, rf_rd, rf_wr, rf_addr, e.wr ? rf_wdata : 8'h00, flag_z, flag_c);
      check("cycle_outputs", 32'(a), 32'(e));
    end
  end

  // ---------------- stimulus helpers (enter and leave at posedge+1) --------
  task automatic preset(input int idx, input logic [7:0] val);
    pre_we = 1'b1; pre_addr = 3'(idx); pre_data = val;
    model_rf[idx] = val;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Builds the expected outputs for cycles 0..done, drives start for cycle 0,
  // and returns at the start of the done cycle.
  task automatic issue(input int op, input int a, input int b, input int d);
    model_t m;
    logic   oz, oc;
    int     lat;
    m = model(op, a, b, d);
    if (exp_q.size() == 0) begin
      oz = cur_z; oc = cur_c;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 3'd0, 8'h00, oz, oc));
    end else begin
      oz = exp_q[$].z; oc = exp_q[$].c;
    end
    if (!m.legal) begin
      exp_q.push_back(mk(0, 1, 1, 0, 0, 3'd0, 8'h00, oz, oc));
      lat = 1;
    end else begin
      exp_q.push_back(mk(1, 0, 0, 1, 0, 3'(a), 8'h00, oz, oc));
      lat = 1;
      if (m.two_src) begin
        exp_q.push_back(mk(1, 0, 0, 1, 0, 3'(b), 8'h00, oz, oc));
        lat++;
      end
      exp_q.push_back(mk(1, 0, 0, 0, 0, 3'd0, 8'h00, oz, oc));
      lat++;
      if (m.wb) begin
        exp_q.push_back(mk(1, 0, 0, 0, 1, 3'(d), m.res, m.z, m.c));
        lat++;
        model_rf[d] = m.res;
      end
      exp_q.push_back(mk(0, 1, 0, 0, 0, 3'd0, 8'h00, m.z, m.c));
      lat++;
    end
    start = 1'b1; opcode = 4'(op); src_a = 3'(a); src_b = 3'(b); dst = 3'(d);
    @(posedge clk); #1;
    start = 1'b0;
    opcode = 4'($urandom_range(0, 15));
    src_a = 3'($urandom); src_b = 3'($urandom); dst = 3'($urandom);
    idle_cycles(lat - 1);
  endtask

  function automatic int rand_idx();
    return ($urandom_range(0, 9) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; opcode = '0; src_a = '0; src_b = '0; dst = '0;
    #1;
    check("reset_outputs",
          32'({busy, done, err, flag_z, flag_c, rf_rd, rf_wr, rf_addr, rf_wdata}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;
    for (int i = 0; i < 6; i++) preset(i, 8'($urandom));

    // ADD 0x7F + 0x81 -> 0x00, Z=1, C=1
    preset(1, 8'h7F); preset(2, 8'h81);
    issue(0, 1, 2, 3);
    check("add_wdata", 32'(rf_mem[3]), 32'h00);
    check("add_flags", 32'({flag_z, flag_c}), 32'b11);
    check("add_done",  32'(done), 32'd1);

    // SHL 0x80 -> 0x00, C=1, Z=1
    preset(4, 8'h80);
    issue(6, 4, 0, 5);
    check("shl_wdata", 32'(rf_mem[5]), 32'h00);
    check("shl_flags", 32'({flag_z, flag_c}), 32'b11);

    // CMP 0x10 - 0x20: borrow, not zero, no writeback (back-to-back start)
    preset(1, 8'h10); preset(2, 8'h20);
    issue(11, 1, 2, 7);
    check("cmp_flags", 32'({flag_z, flag_c}), 32'b01);
    issue(0, 1, 2, 6);
    check("reject_dst", 32'({done, err}), 32'b11);
    check("reject_flags", 32'({flag_z, flag_c}), 32'b01);
    issue(14, 0, 0, 0);
    check("reject_op14", 32'({done, err}), 32'b11);

    // MUL 0x10 * 0x11 = 0x110
    preset(1, 8'h10); preset(2, 8'h11);
    issue(12, 1, 2, 3);
    if (MUL_EN) begin
      check("mul_wdata", 32'(rf_mem[3]), 32'h10);
      check("mul_carry", 32'(flag_c), 32'd1);
    end else begin
      check("mul_reject", 32'({done, err}), 32'b11);
    end

    // Reset during RD_B
    idle_cycles(1);
    chk_en = 1'b0;
    preset(1, 8'h05); preset(2, 8'h06);
    start = 1'b1; opcode = 4'd0; src_a = 3'd1; src_b = 3'd2; dst = 3'd0;
    @(posedge clk); #1;                      // RD_A
    start = 1'b0;
    @(posedge clk); #1;                      // RD_B
    check("rdb_reads", 32'({rf_rd, rf_addr}), 32'({1'b1, 3'd2}));
    #2 rst = 1'b1;
    #1;
    check("rst_async",
          32'({busy, done, rf_rd, rf_wr, rf_addr, flag_z, flag_c}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    cur_z = 1'b0; cur_c = 1'b0;
    chk_en = 1'b1;
    idle_cycles(3);                          // compare process requires done=0
    check("rst_no_write", 32'(rf_mem[0]), 32'(model_rf[0]));
    issue(0, 1, 2, 0);
    check("post_rst_add", 32'(rf_mem[0]), 32'h0B);

    // Randomized instructions with random gaps and occasional register reloads
    for (int n = 0; n < 300; n++) begin
      if (n % 7 == 0) begin
        idle_cycles(1);
        preset($urandom_range(0, 5), 8'($urandom));
      end
      issue($urandom_range(0, 15), rand_idx(), rand_idx(), rand_idx());
      idle_cycles($urandom_range(0, 2));
    end
    idle_cycles(2);
    for (int i = 0; i < 6; i++) check("final_rf", 32'(rf_mem[i]), 32'(model_rf[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
